tt_uio_arbiter: RTL

Arbiter and sequencer for the shared 8-bit bidirectional `uio` pin bank of a Tiny Tapeout user project. Up to `N_REQ` internal requesters each ask for the bus in a given direction. The block grants the bus round-robin and drives `uio_oe`/`uio_out` for output beats. It captures `uio_in` for input beats and inserts turnaround cycles whenever the pin direction flips. It sits directly between the project's internal engines and the top-level `uio_*` ports.

---
 rtl/tt_uio_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tt_uio_arbiter.sv
// tt_uio_arbiter: arbitrates the shared uio pin bank among N_REQ requesters (TT_UIO_ARB_FIXED_PRIO_EN = fixed priority, else round-robin).
// Latency: gnt one edge after req; first beat in that cycle, or TURNAROUND cycles later on a direction flip.
// Backpressure: losers hold req (never dropped); owner ends its burst by dropping req or on reaching MAX_BURST.
module tt_uio_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_dir,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   ack,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    input  logic [7:0]         uio_in,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE = 2'd0, TURN = 2'd1, XFER = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] win, arb_win;
    logic          cur_dir, last_dir;
    logic [3:0]    cnt;
    logic [1:0]    tcnt;
    logic [7:0]    req_bytes [N_REQ];
    logic          start, need_turn, turn_abort, burst_go, drive;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_bytes[i] = req_data[8*i +: 8];
        end
    end

`ifdef TT_UIO_ARB_FIXED_PRIO_EN
    always_comb begin
        arb_win = '0;
        for (int i = N_REQ-1; i >= 0; i--) begin
            if (req[i]) arb_win = IW'(i);
        end
    end
`else
    logic [IW-1:0] ptr;
    logic [IW-1:0] rr_idx;

    // Scan downwards so the candidate closest to ptr is the last one written.
    always_comb begin
        arb_win = '0;
        rr_idx  = '0;
        for (int i = N_REQ-1; i >= 0; i--) begin
            rr_idx = IW'((int'(ptr) + i) % N_REQ);
            if (req[rr_idx]) arb_win = rr_idx;
        end
    end
`endif

    assign start      = ena && (|req);
    assign need_turn  = (req_dir[arb_win] != last_dir) && (TURNAROUND > 0);
    assign turn_abort = !req[win] || !ena;
    assign burst_go   = req[win] && ena && (({1'b0, cnt} + 5'd1) < 5'(MAX_BURST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = need_turn ? TURN : XFER;
            TURN: begin
                if (turn_abort)        state_d = IDLE;
                else if (tcnt == 2'd1) state_d = XFER;
            end
            XFER: if (!burst_go) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            win      <= '0;
            cur_dir  <= 1'b0;
            last_dir <= 1'b0;
            cnt      <= '0;
            tcnt     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
`ifndef TT_UIO_ARB_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            rd_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        win     <= arb_win;
                        cur_dir <= req_dir[arb_win];
                        gnt     <= N_REQ'(1) << arb_win;
                        tcnt    <= 2'(TURNAROUND);
                        cnt     <= '0;
                    end
                end
                TURN: begin
                    if (turn_abort) gnt  <= '0;
                    else            tcnt <= tcnt - 2'd1;
                end
                XFER: begin
                    last_dir <= cur_dir;
                    if (!cur_dir) begin
                        rd_data  <= uio_in;
                        rd_valid <= 1'b1;
                    end
                    if (burst_go) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        gnt <= '0;
`ifndef TT_UIO_ARB_FIXED_PRIO_EN
                        ptr <= (win == IW'(N_REQ-1)) ? '0 : win + 1'b1;
`endif
                    end
                end
                default: gnt <= '0;
            endcase
        end
    end

    // Pins are a pure decode of registered state, so reset forces them low immediately.
    assign drive = (state_q == XFER) && cur_dir;

    always_comb begin
        ack     = (state_q == XFER) ? gnt : '0;
        uio_oe  = drive ? 8'hFF : 8'h00;
        uio_out = drive ? req_bytes[win] : 8'h00;
    end
endmodule
